// File: rtl/iter_solver_seq.sv
// rtl/iter_solver_seq.sv - row-serial Jacobi iteration stage x(k+1) = c + B*x(k)
// One row per cycle; x_cur is double-buffered against x_next so every row of an iteration sees the same x(k).
module iter_solver_seq #(
   parameter int DIM    = 16,
   parameter int WIDTH  = 8,
   parameter int FRAC   = 6,
   parameter int ITER_W = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ITER_W-1:0]            num_iter,
   input  logic [WIDTH-1:0]             tol,
   input  logic [DIM*DIM*WIDTH-1:0]     B_mat,
   input  logic [DIM*WIDTH-1:0]         c_vec,
   input  logic [DIM*WIDTH-1:0]         x_init,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DIM*WIDTH-1:0]         x_out,
   output logic [ITER_W-1:0]            iter_done,
   output logic                         converged,
   output logic                         sat_flag
);
   localparam int RW = $clog2(DIM);
   localparam int AW = 2*WIDTH + $clog2(DIM);
   localparam logic signed [AW:0]      VMAX = (AW+1)'((2**(WIDTH-1)) - 1);
   localparam logic signed [AW:0]      VMIN = -VMAX - 1;
   localparam logic signed [WIDTH-1:0] WMAX = WIDTH'((2**(WIDTH-1)) - 1);
   localparam logic signed [WIDTH-1:0] WMIN = ~WMAX;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;

   logic signed [WIDTH-1:0] b_reg  [DIM][DIM];
   logic signed [WIDTH-1:0] c_reg  [DIM];
   logic signed [WIDTH-1:0] x_cur  [DIM];
   logic signed [WIDTH-1:0] x_next [DIM];
   logic [ITER_W-1:0]       num_reg;
   logic [WIDTH-1:0]        tol_reg;
   logic [RW-1:0]           r;
   logic [ITER_W-1:0]       count;
   logic [WIDTH:0]          maxd;

   logic signed [2*WIDTH-1:0] prod;
   logic signed [AW-1:0]      acc, acc_sh;
   logic signed [AW:0]        v;
   logic                      sat_hi, sat_lo;
   logic signed [WIDTH-1:0]   v_sat;
   logic signed [WIDTH:0]     diff;
   logic [WIDTH:0]            d, maxd_fin;
   logic [ITER_W-1:0]         count_inc;
   logic                      last_row;

   always_comb begin
      prod = '0;
      acc  = '0;
      for (int j = 0; j < DIM; j++) begin
         prod = b_reg[r][j] * x_cur[j];
         acc  = acc + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
      end
      acc_sh   = acc >>> FRAC;
      v        = {acc_sh[AW-1], acc_sh} + {{(AW+1-WIDTH){c_reg[r][WIDTH-1]}}, c_reg[r]};
      sat_hi   = v > VMAX;
      sat_lo   = v < VMIN;
      v_sat    = sat_hi ? WMAX : (sat_lo ? WMIN : v[WIDTH-1:0]);
      diff     = {v_sat[WIDTH-1], v_sat} - {x_cur[r][WIDTH-1], x_cur[r]};
      d        = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      maxd_fin = (d > maxd) ? d : maxd;
      count_inc = count + 1'b1;
      last_row  = (r == RW'(DIM-1));
   end

   always_comb begin
      x_out = '0;
      for (int i = 0; i < DIM; i++) x_out[i*WIDTH +: WIDTH] = x_cur[i];
   end

   assign iter_done = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         converged <= 1'b0;
         sat_flag  <= 1'b0;
         num_reg   <= '0;
         tol_reg   <= '0;
         r         <= '0;
         count     <= '0;
         maxd      <= '0;
         for (int i = 0; i < DIM; i++) begin
            c_reg[i]  <= '0;
            x_cur[i]  <= '0;
            x_next[i] <= '0;
            for (int j = 0; j < DIM; j++) b_reg[i][j] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready  <= 1'b0;
                  num_reg   <= num_iter;
                  tol_reg   <= tol;
                  count     <= '0;
                  converged <= 1'b0;
                  sat_flag  <= 1'b0;
                  r         <= '0;
                  maxd      <= '0;
                  for (int i = 0; i < DIM; i++) begin
                     c_reg[i] <= c_vec[i*WIDTH +: WIDTH];
                     x_cur[i] <= x_init[i*WIDTH +: WIDTH];
                     for (int j = 0; j < DIM; j++)
                        b_reg[i][j] <= B_mat[(i*DIM+j)*WIDTH +: WIDTH];
                  end
                  if (num_iter == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               x_next[r] <= v_sat;
               if (sat_hi || sat_lo) sat_flag <= 1'b1;
               if (last_row) begin
                  for (int i = 0; i < DIM-1; i++) x_cur[i] <= x_next[i];
                  x_cur[DIM-1] <= v_sat;
                  count <= count_inc;
                  r     <= '0;
                  maxd  <= '0;
                  // tolerance wins over the iteration limit when both hit together
                  if (tol_reg != '0 && maxd_fin <= {1'b0, tol_reg}) begin
                     converged <= 1'b1;
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else if (count_inc == num_reg) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end
               end else begin
                  r    <= r + 1'b1;
                  maxd <= maxd_fin;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_solver_seq.sv
// tb/tb_iter_solver_seq.sv - randomized and directed jobs against an arithmetic reference model
module tb_iter_solver_seq;
   localparam int DIM = 4, W = 8, FRAC = 6, IW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [IW-1:0] num_iter = '0;
   logic [W-1:0] tol = '0;
   logic [DIM*DIM*W-1:0] B_mat = '0;
   logic [DIM*W-1:0] c_vec = '0, x_init = '0, x_out;
   logic [IW-1:0] iter_done;
   logic converged, sat_flag;

   always #5 clk = ~clk;

   iter_solver_seq #(.DIM(DIM), .WIDTH(W), .FRAC(FRAC), .ITER_W(IW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .num_iter(num_iter), .tol(tol), .B_mat(B_mat), .c_vec(c_vec), .x_init(x_init),
      .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
      .iter_done(iter_done), .converged(converged), .sat_flag(sat_flag));

   int mb[DIM][DIM];
   int mc[DIM], mx[DIM];
   int exp_x[DIM];
   int exp_it, exp_cv, exp_sat;
   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int xo(input int i);
      logic signed [W-1:0] e;
      e = x_out[i*W +: W];
      return int'(e);
   endfunction

   task automatic model(input int k, input int tl);
      int cur[DIM], nxt[DIM];
      int acc, v, dd, md;
      cur = mx; exp_it = 0; exp_cv = 0; exp_sat = 0;
      while (k != 0) begin
         md = 0;
         for (int i = 0; i < DIM; i++) begin
            acc = 0;
            for (int j = 0; j < DIM; j++) acc += mb[i][j] * cur[j];
            v = (acc >>> FRAC) + mc[i];
            if (v > 127) begin v = 127; exp_sat = 1; end
            if (v < -128) begin v = -128; exp_sat = 1; end
            nxt[i] = v;
            dd = (v > cur[i]) ? v - cur[i] : cur[i] - v;
            if (dd > md) md = dd;
         end
         cur = nxt;
         exp_it++;
         if (tl != 0 && md <= tl) begin exp_cv = 1; break; end
         if (exp_it == k) break;
      end
      exp_x = cur;
   endtask

   task automatic scramble();
      for (int i = 0; i < DIM*DIM; i++) B_mat[i*W +: W] = W'($urandom);
      c_vec = $urandom; x_init = $urandom;
      num_iter = IW'($urandom); tol = W'($urandom);
   endtask

   task automatic start_job(input int k, input int tl);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check("in_ready_before_capture", int'(in_ready), 1);
      for (int i = 0; i < DIM; i++) begin
         c_vec[i*W +: W]  = W'(mc[i]);
         x_init[i*W +: W] = W'(mx[i]);
         for (int j = 0; j < DIM; j++) B_mat[(i*DIM+j)*W +: W] = W'(mb[i][j]);
      end
      num_iter = IW'(k); tol = W'(tl);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
      model(k, tl);
   endtask

   task automatic finish_job(input string tag, input bit hold);
      int lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 2000) begin @(negedge clk); lat++; end
      check({tag, "_latency"}, lat, DIM*exp_it);
      for (int i = 0; i < DIM; i++) check($sformatf("%s_x%0d", tag, i), xo(i), exp_x[i]);
      check({tag, "_iter_done"}, int'(iter_done), exp_it);
      check({tag, "_converged"}, int'(converged), exp_cv);
      check({tag, "_sat_flag"}, int'(sat_flag), exp_sat);
      if (hold) begin
         in_valid = 1'b1;
         repeat (5) begin
            @(negedge clk);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_x0", xo(0), exp_x[0]);
            check("hold_iter_done", int'(iter_done), exp_it);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_out_valid_drop"}, int'(out_valid), 0);
      check({tag, "_in_ready_back"}, int'(in_ready), 1);
      check({tag, "_x0_retained"}, xo(0), exp_x[0]);
   endtask

   task automatic set_zero_b();
      for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mb[i][j] = 0;
   endtask

   task automatic set_diag(input int g);
      set_zero_b();
      for (int i = 0; i < DIM; i++) mb[i][i] = g;
   endtask

   task automatic scen3();
      set_diag(32);
      mc = '{0, 0, 0, 0};
      mx = '{64, -64, 40, -1};
   endtask

   initial begin
      #12;
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_x_out_nonzero", int'(x_out != '0), 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready_after_release", int'(in_ready), 1);

      set_zero_b(); mc = '{10, -5, 3, 0}; mx = '{1, 1, 1, 1};
      start_job(3, 0);  finish_job("zero_b", 1'b0);
      mx = mc;
      start_job(8, 1);  finish_job("early_stop", 1'b0);
      scen3();
      start_job(2, 0);  finish_job("half_diag", 1'b0);
      set_diag(64); mc = '{100, -100, 0, 0}; mx = '{100, -100, 5, 0};
      start_job(1, 0);  finish_job("saturate", 1'b1);
      mx = '{-7, 33, 127, -128};
      start_job(0, 3);  finish_job("k_zero", 1'b0);

      scen3();
      start_job(2, 0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1; #1;
      check("rst_x_out_nonzero", int'(x_out != '0), 0);
      check("rst_iter_done", int'(iter_done), 0);
      check("rst_converged", int'(converged), 0);
      check("rst_sat_flag", int'(sat_flag), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 0);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready_release", int'(in_ready), 1);
      start_job(2, 0);  finish_job("after_rst", 1'b0);

      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < DIM; i++) begin
            mc[i] = int'($urandom_range(0, 80)) - 40;
            mx[i] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < DIM; j++) mb[i][j] = int'($urandom_range(0, 48)) - 24;
         end
         if (n % 5 == 0) mb[n % DIM][n % DIM] = 127;
         start_job(int'($urandom_range(0, 6)),
                   ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8)));
         finish_job($sformatf("rnd%0d", n), (n % 7) == 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
